cache_fill_fsm: RTL and testbench
=================================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 Parameter: WORDS_PER_BLOCK, 8, 16-bit words per cache block (fixed; block = 16 bytes).
REQ-002 Parameter: MEM_LATENCY, 4, cycles from memory_read_en to memory_data_valid (bench model only; the FSM does not count it).
REQ-003 Port: clk  in  1  single clock, rising edge.
REQ-004 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-005 Port: miss_detected  in  1  cache miss request from the cache/pipeline side.
REQ-006 Port: miss_address  in  16  byte address of the missing access.
REQ-007 Port: memory_data  in  16  read data returned by main memory.
REQ-008 Port: memory_data_valid  in  1  memory_data is valid this cycle.
REQ-009 Port: fsm_busy  out  1  fill in progress; drives i_fsm_busy/d_fsm_busy stall.
REQ-010 Port: memory_read_en  out  1  issue one word read to memory this cycle.
REQ-011 Port: memory_address  out  16  word address being issued.
REQ-012 Port: write_data_array  out  1  write fill_data into the data array at data_array_addr.
REQ-013 Port: data_array_addr  out  16  byte address of the word being written.
REQ-014 Port: fill_data  out  16  equal to memory_data (pass-through).
REQ-015 Port: write_tag_array  out  1  one-cycle pulse; write tag/valid for the filled block.

Function
REQ-016 States SHALL be IDLE and FILL only.
REQ-017 IDLE with miss_detected=1 SHALL latch base = {miss_address[15:4],4'b0} and start word = miss_address[3:1], then enter FILL next cycle.
REQ-018 FILL SHALL assert fsm_busy=1; IDLE SHALL assert fsm_busy=0.
REQ-019 In FILL, issue count < 8: memory_read_en=1 and memory_address = base + 2*((start + issue_cnt) mod 8); issue_cnt increments by 1 per cycle; after 8 issues memory_read_en=0.
REQ-020 Issue SHALL begin on the first FILL cycle: miss at cycle T gives issues at T+1..T+8.
REQ-021 In FILL, memory_data_valid=1 SHALL assert write_data_array combinationally in the same cycle, with data_array_addr = base + 2*((start + recv_cnt) mod 8); recv_cnt then increments.
REQ-022 Cycles with memory_data_valid=0 (gaps) SHALL not advance recv_cnt or write.
REQ-023 When memory_data_valid=1 with recv_cnt=7: write_tag_array=1 in the same cycle, and the next state is IDLE.
REQ-024 With MEM_LATENCY=4 and no gaps, a miss at T SHALL give data writes at T+5..T+12, the tag write at T+12, and fsm_busy=0 from T+13.
REQ-025 Word offsets SHALL wrap mod 8 within the block; base[15:4] SHALL never change during a fill.
REQ-026 miss_detected during FILL, or on the cycle FILL exits, SHALL be ignored; a new fill requires miss_detected in IDLE.
REQ-027 memory_data_valid in IDLE SHALL be ignored: no write_data_array and no write_tag_array.
REQ-028 memory_address and data_array_addr SHALL read 16'h0000 when their strobe is low.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, issue_cnt=0, recv_cnt=0, base=0 and start=0.
REQ-030 During reset all outputs SHALL be 0, except fill_data, which passes memory_data.
REQ-031 Reset during FILL SHALL abort the fill: no write_tag_array; a later valid in IDLE is ignored.

Configuration
REQ-032 Macro CACHE_FILL_CRITICAL_WORD_FIRST_EN defined: start = miss_address[3:1] (critical word first, wrapping).
REQ-033 Macro undefined: start SHALL be tied to 0 (sequential order 0..7); all other behaviour is unchanged.

Structure
REQ-034 Shared package cache_pkg SHALL hold the state enum (IDLE, FILL), WORDS_PER_BLOCK, BLOCK_OFFSET_W=4 and WORD_IDX_W=3.
REQ-035 One sub-module, fill_word_cnt (3-bit counter with enable, sync clear and done flag), SHALL be instantiated twice: issue counter and receive counter.

Verification
REQ-036 Miss at addr 16'h1234, macro undefined, latency 4: issues 1230,1232..123E at T+1..T+8; writes same order T+5..T+12; tag at T+12; busy low T+13.
REQ-037 Same miss, macro defined: issue/write order 1234,1236,1238,123A,123C,123E,1230,1232.
REQ-038 Valid gaps (drop valid every other cycle): exactly 8 writes, tag on the 8th, busy held until then.
REQ-039 miss_detected pulsed at 16'h5000 mid-fill of 16'h1234: ignored; base stays 16'h1230; only one tag write.
REQ-040 rst_n=0 after 3 data writes: next cycle IDLE, busy=0; following valids cause no writes; no tag write.
REQ-041 memory_data_valid=1 while IDLE with no miss: write_data_array and write_tag_array stay 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache block fill engine.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fillState_e;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int BLOCK_OFFSET_W  = 4;
    localparam int WORD_IDX_W      = 3;

    // Byte address of a 16-bit word: block base plus twice the word index.
    function automatic logic [15:0] wordAddr(input logic [15:BLOCK_OFFSET_W] blockHi,
                                             input logic [WORD_IDX_W-1:0] idx);
        return {blockHi, idx, 1'b0};
    endfunction

endpackage

// File: rtl/fill_word_cnt.sv
// Word counter for one block: counts enabled cycles 0..7 and flags completion
// after the eighth; a synchronous clear rearms it for the next fill.
module fill_word_cnt
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  en,
    output logic [WORD_IDX_W-1:0] count,
    output logic                  done
);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
            done  <= 1'b0;
        end else if (en && !done) begin
            count <= count + 1'b1;
            if (count == WORD_IDX_W'(WORDS_PER_BLOCK - 1))
                done <= 1'b1;
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache block fill controller: issues eight word reads and writes returning data.
// Define CACHE_FILL_CRITICAL_WORD_FIRST_EN to start at the missed word and wrap.
module cache_fill_fsm
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic [15:0] memory_data,
    input  logic        memory_data_valid,
    output logic        fsm_busy,
    output logic        memory_read_en,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [15:0] data_array_addr,
    output logic [15:0] fill_data,
    output logic        write_tag_array
);

    fillState_e                state;
    fillState_e                nextState;
    logic [15:BLOCK_OFFSET_W]  baseHi;
    logic [WORD_IDX_W-1:0]     startIdx;
    logic [WORD_IDX_W-1:0]     issueCnt;
    logic [WORD_IDX_W-1:0]     recvCnt;
    logic                      issueDone;
    logic                      recvDone;
    logic                      cntClear;
    logic                      unusedBits;

    assign cntClear  = (state == IDLE);
    assign fill_data = memory_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baseHi   <= '0;
            startIdx <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && miss_detected) begin
                baseHi <= miss_address[15:BLOCK_OFFSET_W];
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
                startIdx <= miss_address[BLOCK_OFFSET_W-1:1];
`else
                startIdx <= '0;
`endif
            end
        end
    end

    // Outputs are gated by rst_n so a reset cycle mid-fill is silent.
    always_comb begin
        nextState        = state;
        fsm_busy         = 1'b0;
        memory_read_en   = 1'b0;
        memory_address   = 16'h0000;
        write_data_array = 1'b0;
        data_array_addr  = 16'h0000;
        write_tag_array  = 1'b0;
        case (state)
            IDLE: begin
                if (miss_detected)
                    nextState = FILL;
            end
            FILL: begin
                fsm_busy       = rst_n;
                memory_read_en = rst_n && !issueDone;
                if (memory_read_en)
                    memory_address = wordAddr(baseHi, startIdx + issueCnt);
                write_data_array = rst_n && memory_data_valid;
                if (write_data_array)
                    data_array_addr = wordAddr(baseHi, startIdx + recvCnt);
                write_tag_array = write_data_array &&
                                  (recvCnt == WORD_IDX_W'(WORDS_PER_BLOCK - 1));
                if (write_tag_array)
                    nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    fill_word_cnt u_issueCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cntClear),
        .en    (memory_read_en),
        .count (issueCnt),
        .done  (issueDone)
    );

    fill_word_cnt u_recvCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cntClear),
        .en    (write_data_array),
        .count (recvCnt),
        .done  (recvDone)
    );

    // The block ends on the eighth write, so the receive done flag is never consulted.
    assign unusedBits = ^{recvDone, miss_address[BLOCK_OFFSET_W-1:0]};

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: vector table, directed fill sequences and a
// randomized run against a queue-based model of a block fill with a latency memory.
module tb_cache_fill_fsm;

    localparam int MEM_LATENCY = 4;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    localparam logic [15:0] A0 = 16'h1234;
    localparam logic [15:0] A1 = 16'h1236;
    localparam logic [15:0] A2 = 16'h1238;
`else
    localparam logic [15:0] A0 = 16'h1230;
    localparam logic [15:0] A1 = 16'h1232;
    localparam logic [15:0] A2 = 16'h1234;
`endif

    logic        clk;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        memory_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] data_array_addr;
    logic [15:0] fill_data;
    logic        write_tag_array;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .memory_read_en    (memory_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .data_array_addr   (data_array_addr),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tot = 0;
    int bad = 0;
    int cyc = 0;

    // model state
    bit          mBusy;
    logic [15:0] expIssue_q[$];
    logic [15:0] expWrite_q[$];
    logic [15:0] pendAddr_q[$];
    int          pendDue_q[$];
    bit          altToggle;
    int          fillsStarted;

    // observation logs
    int          writesSeen;
    int          tagsSeen;
    int          missCyc;
    int          tagOff;
    int          writeOff_q[$];
    logic [15:0] issueLog_q[$];

    typedef struct {
        logic        rst;
        logic        miss;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] data;
        logic        eBusy;
        logic        eRead;
        logic [15:0] eMaddr;
        logic        eWrite;
        logic [15:0] eDaddr;
        logic        eTag;
    } vec_t;

    vec_t        vecs[9];
    logic [15:0] ordA[8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    function automatic int startOf(input logic [15:0] a);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        return int'(a[3:1]);
`else
        return 0;
`endif
    endfunction

    function automatic logic [15:0] fillAddr(input logic [15:0] a, input int i);
        logic [15:0] b;
        b = {a[15:4], 4'h0};
        return b + 16'(2 * ((startOf(a) + i) % 8));
    endfunction

    task automatic resetLogs();
        writesSeen = 0;
        tagsSeen   = 0;
        tagOff     = -1;
        writeOff_q.delete();
        issueLog_q.delete();
    endtask

    // driver + model check for one clock cycle
    task automatic step(input logic rstIn, input logic missIn, input logic [15:0] addrIn,
                        input int gapMode, input logic spurious);
        logic        gap, live, eRead, eWrite, eTag;
        logic [15:0] eMaddr, eDaddr;
        bit          fromPend;
        @(negedge clk);
        rst_n         = rstIn;
        miss_detected = missIn;
        miss_address  = addrIn;
        gap = 1'b0;
        if (gapMode == 1) begin
            gap       = altToggle;
            altToggle = !altToggle;
        end else if (gapMode == 2) begin
            gap = ($urandom_range(0, 2) == 0);
        end
        fromPend = (pendAddr_q.size() > 0) && (pendDue_q[0] <= cyc) && !gap;
        if (fromPend) begin
            memory_data_valid = 1'b1;
            memory_data       = pendAddr_q[0] ^ 16'h5A3C;
        end else begin
            memory_data_valid = spurious && !mBusy;
            memory_data       = 16'($urandom);
        end
        #1;
        live   = rstIn && mBusy;
        eRead  = live && (expIssue_q.size() > 0);
        eMaddr = eRead ? expIssue_q[0] : 16'h0000;
        eWrite = live && memory_data_valid;
        eDaddr = eWrite ? expWrite_q[0] : 16'h0000;
        eTag   = eWrite && (expWrite_q.size() == 1);
        chk("busy",      {15'b0, fsm_busy},         {15'b0, live});
        chk("read_en",   {15'b0, memory_read_en},   {15'b0, eRead});
        chk("mem_addr",  memory_address,            eMaddr);
        chk("wr_data",   {15'b0, write_data_array}, {15'b0, eWrite});
        chk("arr_addr",  data_array_addr,           eDaddr);
        chk("wr_tag",    {15'b0, write_tag_array},  {15'b0, eTag});
        chk("fill_data", fill_data,                 memory_data);

        if (write_data_array === 1'b1) begin
            writesSeen++;
            writeOff_q.push_back(cyc - missCyc);
        end
        if (write_tag_array === 1'b1) begin
            tagsSeen++;
            tagOff = cyc - missCyc;
        end
        if (memory_read_en === 1'b1)
            issueLog_q.push_back(memory_address);

        if (!rstIn) begin
            mBusy = 1'b0;
            expIssue_q.delete();
            expWrite_q.delete();
        end else if (mBusy) begin
            if (eRead) begin
                pendAddr_q.push_back(expIssue_q[0]);
                pendDue_q.push_back(cyc + MEM_LATENCY);
                void'(expIssue_q.pop_front());
            end
            if (eWrite) begin
                void'(expWrite_q.pop_front());
                if (expWrite_q.size() == 0)
                    mBusy = 1'b0;
            end
        end else if (missIn) begin
            for (int i = 0; i < 8; i++) begin
                expIssue_q.push_back(fillAddr(addrIn, i));
                expWrite_q.push_back(fillAddr(addrIn, i));
            end
            mBusy   = 1'b1;
            missCyc = cyc;
            fillsStarted++;
        end
        if (fromPend) begin
            void'(pendAddr_q.pop_front());
            void'(pendDue_q.pop_front());
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic runToIdle(input string name, input int gapMode, input int budget);
        for (int i = 0; i < budget && mBusy; i++)
            step(1'b1, 1'b0, 16'h0000, gapMode, 1'b0);
        chk(name, {15'b0, mBusy}, 16'h0000);
    endtask

    initial begin
        rst_n             = 1'b0;
        miss_detected     = 1'b0;
        miss_address      = 16'h0000;
        memory_data       = 16'h0000;
        memory_data_valid = 1'b0;
        mBusy             = 1'b0;
        altToggle         = 1'b0;
        fillsStarted      = 0;
        missCyc           = 0;
        resetLogs();

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
        ordA = '{16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232};
`else
        ordA = '{16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E};
`endif

        //            rst   miss  addr      valid data      busy  read  maddr     wr    daddr     tag
        vecs[0] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hA5A5, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'h1234, 1'b0, 16'h0F0F, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 16'h1234, 1'b0, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h3333, 1'b1, 1'b1, A0,       1'b0, 16'h0000, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 16'h5000, 1'b0, 16'h4444, 1'b1, 1'b1, A1,       1'b0, 16'h0000, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h7777, 1'b1, 1'b1, A2,       1'b1, A0,       1'b0};
        vecs[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h8888, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h9999, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rst_n             = vecs[i].rst;
            miss_detected     = vecs[i].miss;
            miss_address      = vecs[i].addr;
            memory_data_valid = vecs[i].valid;
            memory_data       = vecs[i].data;
            #1;
            chk("vec_busy",  {15'b0, fsm_busy},         {15'b0, vecs[i].eBusy});
            chk("vec_read",  {15'b0, memory_read_en},   {15'b0, vecs[i].eRead});
            chk("vec_maddr", memory_address,            vecs[i].eMaddr);
            chk("vec_wr",    {15'b0, write_data_array}, {15'b0, vecs[i].eWrite});
            chk("vec_daddr", data_array_addr,           vecs[i].eDaddr);
            chk("vec_tag",   {15'b0, write_tag_array},  {15'b0, vecs[i].eTag});
            chk("vec_fill",  fill_data,                 vecs[i].data);
            @(posedge clk);
            cyc++;
        end

        // nominal fill of 0x1234 with fixed latency and no gaps
        resetLogs();
        step(1'b1, 1'b1, 16'h1234, 0, 1'b0);
        runToIdle("fillA_timeout", 0, 30);
        step(1'b1, 1'b0, 16'h0000, 0, 1'b0);
        chk("fillA_issues", 16'(issueLog_q.size()), 16'd8);
        for (int i = 0; i < 8 && i < issueLog_q.size(); i++)
            chk("fillA_order", issueLog_q[i], ordA[i]);
        chk("fillA_writes", 16'(writeOff_q.size()), 16'd8);
        for (int i = 0; i < 8 && i < writeOff_q.size(); i++)
            chk("fillA_wr_time", 16'(writeOff_q[i]), 16'(i + 5));
        chk("fillA_tag_time", 16'(tagOff), 16'd12);
        chk("fillA_tags", 16'(tagsSeen), 16'd1);

        // valid dropped every other cycle
        resetLogs();
        altToggle = 1'b1;
        step(1'b1, 1'b1, 16'h8ACE, 1, 1'b0);
        runToIdle("fillB_timeout", 1, 60);
        chk("fillB_writes", 16'(writesSeen), 16'd8);
        chk("fillB_tags", 16'(tagsSeen), 16'd1);

        // miss pulses during the fill are ignored
        resetLogs();
        step(1'b1, 1'b1, 16'h1234, 0, 1'b0);
        for (int i = 0; i < 30 && mBusy; i++)
            step(1'b1, (i == 2 || i == 6), (i == 2) ? 16'h5000 : 16'h5006, 0, 1'b0);
        chk("fillC_timeout", {15'b0, mBusy}, 16'h0000);
        for (int i = 0; i < issueLog_q.size(); i++)
            chk("fillC_base", {4'h0, issueLog_q[i][15:4]}, 16'h0123);
        chk("fillC_writes", 16'(writesSeen), 16'd8);
        chk("fillC_tags", 16'(tagsSeen), 16'd1);

        // reset after three data writes aborts the fill
        resetLogs();
        step(1'b1, 1'b1, 16'h2468, 0, 1'b0);
        for (int i = 0; i < 30 && writesSeen < 3; i++)
            step(1'b1, 1'b0, 16'h0000, 0, 1'b0);
        chk("fillD_three", 16'(writesSeen), 16'd3);
        step(1'b0, 1'b0, 16'h0000, 0, 1'b0);
        for (int i = 0; i < 12; i++)
            step(1'b1, 1'b0, 16'h0000, 0, 1'b1);
        for (int i = 0; i < 20 && pendAddr_q.size() > 0; i++)
            step(1'b1, 1'b0, 16'h0000, 0, 1'b0);
        chk("fillD_writes", 16'(writesSeen), 16'd3);
        chk("fillD_tags", 16'(tagsSeen), 16'd0);

        // randomized misses, gaps, stray valids and mid-fill misses
        resetLogs();
        fillsStarted = 0;
        for (int i = 0; i < 600; i++)
            step(1'b1, ($urandom_range(0, 3) == 0), 16'($urandom), 2,
                 ($urandom_range(0, 3) == 0));
        runToIdle("rand_timeout", 2, 100);
        chk("rand_tags", 16'(tagsSeen), 16'(fillsStarted));
        chk("rand_writes", 16'(writesSeen), 16'(8 * fillsStarted));

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog at cycle %0d: got timeout want completion", cyc);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
